// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating sum of N_TERMS 4-bit products per frame,
// with valid/ready handshakes on both the product and the result side.
module mac_accumulator #(
  parameter int ACC_W   = 8,
  parameter int N_TERMS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             in_valid_i,
  input  logic [3:0]       p_i,
  output logic             in_ready_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             in_ready;
  logic             accept;
  logic             last;
  logic             ovr;
  logic [ACC_W:0]   sum;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: abort wins, then result handshake, then final accept
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: if (accept && last) state_d = DONE;
        DONE:  if (out_ready_i)    state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Outputs: everything but in_ready comes straight from registers
  always_comb begin
    in_ready    = (state_q == ACCUM) & ~clr_i;
    in_ready_o  = in_ready;
    out_valid_o = (state_q == DONE);
    acc_o       = acc_q;
    ovf_o       = ovf_q;
  end

  // Datapath next values: saturating add and term counting
  always_comb begin
    accept = in_valid_i & in_ready;
    last   = (cnt_q == LAST);
    sum    = {1'b0, acc_q} + (ACC_W + 1)'(p_i);
    ovr    = sum[ACC_W];
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (state_q == DONE && out_ready_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      acc_d = ovr ? '1 : sum[ACC_W-1:0];
      ovf_d = ovf_q | ovr;
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed vector table plus hand sequences
// for saturation, N_TERMS=1, random stalls and async reset.
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst_n, clr, iv, ordy;
  logic [3:0] p;

  logic       rdy_a, ov_a, ovf_a;
  logic [7:0] acc_a;
  logic       rdy_b, ov_b, ovf_b;
  logic [4:0] acc_b;
  logic       rdy_c, ov_c, ovf_c;
  logic [3:0] acc_c;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(8), .N_TERMS(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(iv), .p_i(p), .in_ready_o(rdy_a),
    .acc_o(acc_a), .out_valid_o(ov_a),
    .out_ready_i(ordy), .ovf_o(ovf_a));

  mac_accumulator #(.ACC_W(5), .N_TERMS(5)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(iv), .p_i(p), .in_ready_o(rdy_b),
    .acc_o(acc_b), .out_valid_o(ov_b),
    .out_ready_i(ordy), .ovf_o(ovf_b));

  mac_accumulator #(.ACC_W(4), .N_TERMS(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(iv), .p_i(p), .in_ready_o(rdy_c),
    .acc_o(acc_c), .out_valid_o(ov_c),
    .out_ready_i(ordy), .ovf_o(ovf_c));

  typedef struct {
    logic       clr;
    logic       iv;
    logic [3:0] p;
    logic       ordy;
    logic       rdy;
    logic [7:0] acc;
    logic       ov;
    logic       ovf;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic v, input int pp,
                     input logic o, input logic r, input int a,
                     input logic vo, input logic f);
    vec_t e;
    e.clr = c; e.iv = v; e.p = 4'(pp); e.ordy = o;
    e.rdy = r; e.acc = 8'(a); e.ov = vo; e.ovf = f;
    tv.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0; iv = 1'b0; p = '0; ordy = 1'b0;
    #12;
    chk("rst_acc", acc_a, 0);
    chk("rst_ov", ov_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_rdy", rdy_a, 1);
    rst_n = 1'b1;

    // frame 3,2,1,3 held until out_ready
    add(0,1,3,0, 1,3,0,0);
    add(0,1,2,0, 1,5,0,0);
    add(0,1,1,0, 1,6,0,0);
    add(0,1,3,0, 1,9,1,0);
    add(0,1,5,0, 0,9,1,0);
    add(0,0,0,1, 0,0,0,0);
    // back-to-back 9s, out_ready tied high
    for (int f = 0; f < 2; f++) begin
      add(0,1,9,1, 1,9,0,0);
      add(0,1,9,1, 1,18,0,0);
      add(0,1,9,1, 1,27,0,0);
      add(0,1,9,1, 1,36,1,0);
      add(0,1,9,1, 0,0,0,0);
    end
    // abort mid-frame, then a full frame of 2s
    add(0,1,5,0, 1,5,0,0);
    add(0,1,4,0, 1,9,0,0);
    add(1,1,7,0, 0,0,0,0);
    add(0,1,2,0, 1,2,0,0);
    add(0,1,2,0, 1,4,0,0);
    add(0,1,2,0, 1,6,0,0);
    add(0,1,2,0, 1,8,1,0);
    // abort while holding a result
    add(1,1,2,0, 0,0,0,0);
    add(0,0,0,0, 1,0,0,0);
    // products above 9, with a bubble
    add(0,1,15,0, 1,15,0,0);
    add(0,0,7,0,  1,15,0,0);
    add(0,1,15,0, 1,30,0,0);
    add(0,1,15,0, 1,45,0,0);
    add(0,1,15,0, 1,60,1,0);
    add(0,0,0,1,  0,0,0,0);

    foreach (tv[i]) begin
      clr = tv[i].clr; iv = tv[i].iv;
      p = tv[i].p; ordy = tv[i].ordy;
      #1;
      chk($sformatf("v%0d_rdy", i), rdy_a, tv[i].rdy);
      step();
      chk($sformatf("v%0d_acc", i), acc_a, tv[i].acc);
      chk($sformatf("v%0d_ov", i), ov_a, tv[i].ov);
      chk($sformatf("v%0d_ovf", i), ovf_a, tv[i].ovf);
    end
    clr = 1'b0; iv = 1'b0; ordy = 1'b0;

    // random in_valid, unit products
    rst_pulse();
    n = 0;
    p = 4'd1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      iv = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_rdy", rdy_a, 1);
      if (iv) n++;
      step();
      chk("rnd_acc", acc_a, n);
      chk("rnd_ov", ov_a, (n == 4) ? 1 : 0);
    end
    chk("rnd_done", n, 4);
    iv = 1'b0;

    // 5-bit accumulator saturates on the 4th 9 and stays there
    rst_pulse();
    for (int k = 0; k < 5; k++) begin
      iv = 1'b1; p = 4'd9; ordy = 1'b0;
      step();
      chk($sformatf("sat%0d_acc", k), acc_b,
          (9 * (k + 1) > 31) ? 31 : 9 * (k + 1));
      chk($sformatf("sat%0d_ovf", k), ovf_b, (k >= 3) ? 1 : 0);
      chk($sformatf("sat%0d_ov", k), ov_b, (k == 4) ? 1 : 0);
    end
    iv = 1'b0; ordy = 1'b1;
    step();
    chk("sat_rel_acc", acc_b, 0);
    chk("sat_rel_ovf", ovf_b, 0);
    iv = 1'b1; ordy = 1'b0;
    step();
    chk("sat_next_acc", acc_b, 9);
    chk("sat_next_ovf", ovf_b, 0);

    // single-term frames
    rst_pulse();
    iv = 1'b1; p = 4'd7; ordy = 1'b0;
    step();
    chk("n1_acc", acc_c, 7);
    chk("n1_ov", ov_c, 1);
    p = 4'd3;
    #1;
    chk("n1_rdy", rdy_c, 0);
    step();
    chk("n1_hold", acc_c, 7);
    iv = 1'b0; ordy = 1'b1;
    step();
    chk("n1_rel", acc_c, 0);
    chk("n1_rel_ov", ov_c, 0);
    iv = 1'b1; p = 4'd15; ordy = 1'b0;
    step();
    chk("n1_acc15", acc_c, 15);
    chk("n1_ovf15", ovf_c, 0);

    // async reset mid-frame
    rst_pulse();
    iv = 1'b1; p = 4'd3;
    step();
    step();
    chk("mid_acc", acc_a, 6);
    iv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", acc_a, 0);
    chk("mid_rst_ov", ov_a, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy", rdy_a, 1);

    // async reset while holding a result
    step();
    iv = 1'b1; p = 4'd9;
    for (int k = 0; k < 4; k++) step();
    iv = 1'b0;
    chk("done_ov", ov_a, 1);
    chk("done_ovf_b", ovf_b, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("done_rst_acc", acc_a, 0);
    chk("done_rst_ov", ov_a, 0);
    chk("done_rst_acc_b", acc_b, 0);
    chk("done_rst_ovf_b", ovf_b, 0);
    rst_n = 1'b1;
    #1;
    chk("done_rst_rdy", rdy_a, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
